// File: rtl/tdc_pkg.sv
// Shared widths, channel indices and FSM states for the TDC pulse-pair generator.
// Also holds the coincidence word encoding used by the TDC decoder.
package tdc_pkg;

  localparam int CH_W  = 2;
  localparam int INT_W = 7;
  localparam int T_W   = 8;

  localparam int CH_P1 = 0;
  localparam int CH_P2 = 1;

  localparam logic [CH_W-1:0] START_COINC = 2'b00;
  localparam logic [CH_W-1:0] END_COINC   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    GAP
  } state_t;

endpackage

// File: rtl/tdc_pulse_chan.sv
// Per-channel edge shaper: decides whether one output is high at clock t
// of a FIRE window, given start/end membership and the interval.
module tdc_pulse_chan
  import tdc_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [T_W-1:0]   t,
  input  logic [INT_W-1:0] i,
  input  logic             s,
  input  logic             e,
  output logic             out
);

  logic [T_W-1:0] i_ext;
  logic [T_W-1:0] i_end;
  logic           start_on;
  logic           end_on;
  logic           split;

  assign i_ext = T_W'(i);
  assign i_end = i_ext + T_W'(W);

  assign start_on = s && (t < T_W'(W));
  // drop the start pulse one clock early so the end edge is a real rise
  assign split    = e && (i != '0) && (t == i_ext - 8'd1);
  assign end_on   = e && (t >= i_ext) && (t < i_end);

  assign out = (start_on && !split) || end_on;

endmodule

// File: rtl/tdc_pulse_pair_gen.sv
// Pulse-pair generator: one command in, start/end pulses out, then a holdoff.
// Define TDC_PULSE_GEN_COUNT_EN to add the saturating pair_count output.
module tdc_pulse_pair_gen
  import tdc_pkg::*;
#(
  parameter int PULSE_WIDTH = 2,
  parameter int HOLDOFF     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_start,
  input  logic [1:0]  cmd_end,
  input  logic [6:0]  cmd_interval,
  output logic        pulse1,
  output logic        pulse2,
  output logic        busy,
  output logic        done,
  output logic        err_clamp
`ifdef TDC_PULSE_GEN_COUNT_EN
  ,
  output logic [15:0] pair_count
`endif
);

  state_t            state, state_nxt;
  logic [T_W-1:0]    t, t_nxt;
  logic [CH_W-1:0]   s_q, s_nxt;
  logic [CH_W-1:0]   e_q, e_nxt;
  logic [INT_W-1:0]  i_q, i_nxt;
  logic [T_W-1:0]    last;
  logic              clamp;
  logic              done_nxt;
  logic              clamp_nxt;
  logic [CH_W-1:0]   ch_out;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign clamp = (|(cmd_start & cmd_end)) && (cmd_interval == 7'd1);

  always_comb begin
    last = T_W'(PULSE_WIDTH - 1);
    if (s_q == '0 && e_q == '0)
      last = '0;
    else if (e_q != '0)
      last = T_W'(i_q) + T_W'(PULSE_WIDTH - 1);
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    s_nxt     = s_q;
    e_nxt     = e_q;
    i_nxt     = i_q;
    done_nxt  = 1'b0;
    clamp_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          s_nxt     = cmd_start;
          e_nxt     = cmd_end;
          i_nxt     = clamp ? 7'd2 : cmd_interval;
          clamp_nxt = clamp;
          t_nxt     = '0;
          state_nxt = FIRE;
        end
      end
      FIRE: begin
        if (t == last) begin
          t_nxt     = '0;
          done_nxt  = 1'b1;
          state_nxt = GAP;
        end else begin
          t_nxt = t + 8'd1;
        end
      end
      GAP: begin
        if (t == T_W'(HOLDOFF - 1))
          state_nxt = IDLE;
        else
          t_nxt = t + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // channels see next-cycle values so the outputs can be registered
  tdc_pulse_chan #(.W(PULSE_WIDTH)) u_ch1 (
    .t   (t_nxt),
    .i   (i_nxt),
    .s   (s_nxt[CH_P1]),
    .e   (e_nxt[CH_P1]),
    .out (ch_out[CH_P1])
  );

  tdc_pulse_chan #(.W(PULSE_WIDTH)) u_ch2 (
    .t   (t_nxt),
    .i   (i_nxt),
    .s   (s_nxt[CH_P2]),
    .e   (e_nxt[CH_P2]),
    .out (ch_out[CH_P2])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      t         <= '0;
      s_q       <= '0;
      e_q       <= '0;
      i_q       <= '0;
      pulse1    <= 1'b0;
      pulse2    <= 1'b0;
      done      <= 1'b0;
      err_clamp <= 1'b0;
    end else begin
      state     <= state_nxt;
      t         <= t_nxt;
      s_q       <= s_nxt;
      e_q       <= e_nxt;
      i_q       <= i_nxt;
      pulse1    <= (state_nxt == FIRE) && ch_out[CH_P1];
      pulse2    <= (state_nxt == FIRE) && ch_out[CH_P2];
      done      <= done_nxt;
      err_clamp <= clamp_nxt;
    end
  end

`ifdef TDC_PULSE_GEN_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      pair_count <= '0;
    else if (done && pair_count != 16'hFFFF)
      pair_count <= pair_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_tdc_pulse_pair_gen.sv
// Directed bench for tdc_pulse_pair_gen: per-cycle output vectors vs
// hand-derived masks, indexed by t (0 = first cycle after acceptance).
`timescale 1ns/1ps
module tb_tdc_pulse_pair_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_start = 2'b00;
  logic [1:0]  cmd_end = 2'b00;
  logic [6:0]  cmd_interval = 7'd0;
  logic        pulse1, pulse2, busy, done, err_clamp;
`ifdef TDC_PULSE_GEN_COUNT_EN
  logic [15:0] pair_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [255:0] g_p1, g_p2, g_done, g_clamp, g_busy, g_ready;

  always #5 clk = ~clk;

  tdc_pulse_pair_gen #(.PULSE_WIDTH(2), .HOLDOFF(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_start    (cmd_start),
    .cmd_end      (cmd_end),
    .cmd_interval (cmd_interval),
    .pulse1       (pulse1),
    .pulse2       (pulse2),
    .busy         (busy),
    .done         (done),
    .err_clamp    (err_clamp)
`ifdef TDC_PULSE_GEN_COUNT_EN
    ,
    .pair_count   (pair_count)
`endif
  );

  function automatic logic [255:0] rng(input int lo, input int hi);
    logic [255:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  task automatic launch(input logic [1:0] s, input logic [1:0] e,
                        input logic [6:0] i);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      $display("FAIL launch_timeout cmd_ready=%b required=1", cmd_ready);
      errors++;
    end
    cmd_start    = s;
    cmd_end      = e;
    cmd_interval = i;
    cmd_valid    = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    cmd_start    = 2'b11;
    cmd_end      = 2'b11;
    cmd_interval = 7'd77;
  endtask

  task automatic capture(input int n);
    g_p1 = '0; g_p2 = '0; g_done = '0;
    g_clamp = '0; g_busy = '0; g_ready = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      g_p1[k]    = pulse1;
      g_p2[k]    = pulse2;
      g_done[k]  = done;
      g_clamp[k] = err_clamp;
      g_busy[k]  = busy;
      g_ready[k] = cmd_ready;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pulse1, pulse2, busy, done, err_clamp, cmd_ready} !== 6'b000001) begin
      $display("FAIL reset_outputs got=%b required=000001",
               {pulse1, pulse2, busy, done, err_clamp, cmd_ready});
      errors++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_release ready=%b busy=%b required 1/0",
               cmd_ready, busy);
      errors++;
    end
  endtask

  task automatic test_same_channel;
    launch(2'b01, 2'b01, 7'd5);
    capture(14);
    checks++;
    if (g_p1 !== (rng(0, 1) | rng(5, 6))) begin
      $display("FAIL same_p1 got=%h required=%h", g_p1, rng(0, 1) | rng(5, 6));
      errors++;
    end
    checks++;
    if (g_p2 !== '0) begin
      $display("FAIL same_p2 got=%h required=0", g_p2);
      errors++;
    end
    checks++;
    if (g_done !== rng(7, 7)) begin
      $display("FAIL same_done got=%h required=%h", g_done, rng(7, 7));
      errors++;
    end
    checks++;
    if (g_ready !== rng(11, 13) || g_busy !== rng(0, 10)) begin
      $display("FAIL same_ready_busy got=%h/%h required=%h/%h",
               g_ready, g_busy, rng(11, 13), rng(0, 10));
      errors++;
    end
    checks++;
    if (g_clamp !== '0) begin
      $display("FAIL same_clamp got=%h required=0", g_clamp);
      errors++;
    end
  endtask

  task automatic test_coincidence;
    launch(2'b00, 2'b11, 7'd0);
    capture(8);
    checks++;
    if (g_p1 !== rng(0, 1) || g_p2 !== rng(0, 1)) begin
      $display("FAIL coinc_pulses got=%h/%h required=%h", g_p1, g_p2, rng(0, 1));
      errors++;
    end
    checks++;
    if (g_done !== rng(2, 2) || g_ready !== rng(6, 7)) begin
      $display("FAIL coinc_done_ready got=%h/%h required=%h/%h",
               g_done, g_ready, rng(2, 2), rng(6, 7));
      errors++;
    end
  endtask

  task automatic test_clamp;
    launch(2'b11, 2'b01, 7'd1);
    capture(10);
    checks++;
    if (g_clamp !== rng(0, 0)) begin
      $display("FAIL clamp_strobe got=%h required=%h", g_clamp, rng(0, 0));
      errors++;
    end
    checks++;
    if (g_p1 !== (rng(0, 0) | rng(2, 3))) begin
      $display("FAIL clamp_p1 got=%h required=%h", g_p1, rng(0, 0) | rng(2, 3));
      errors++;
    end
    checks++;
    if (g_p2 !== rng(0, 1) || g_done !== rng(4, 4)) begin
      $display("FAIL clamp_p2_done got=%h/%h required=%h/%h",
               g_p2, g_done, rng(0, 1), rng(4, 4));
      errors++;
    end
  endtask

  task automatic test_max_interval;
    launch(2'b10, 2'b01, 7'd127);
    capture(140);
    checks++;
    if (g_p2 !== rng(0, 1) || g_p1 !== rng(127, 128)) begin
      $display("FAIL maxint_pulses got=%h/%h required=%h/%h",
               g_p1, g_p2, rng(127, 128), rng(0, 1));
      errors++;
    end
    checks++;
    if (g_done !== rng(129, 129) || g_busy !== rng(0, 132)) begin
      $display("FAIL maxint_done_busy got=%h/%h required=%h/%h",
               g_done, g_busy, rng(129, 129), rng(0, 132));
      errors++;
    end
  endtask

  task automatic test_null;
    launch(2'b00, 2'b00, 7'd9);
    capture(8);
    checks++;
    if (g_p1 !== '0 || g_p2 !== '0 || g_done !== rng(1, 1)) begin
      $display("FAIL null_cmd got=%h/%h/%h required=0/0/%h",
               g_p1, g_p2, g_done, rng(1, 1));
      errors++;
    end
    checks++;
    if (g_busy !== rng(0, 4) || g_ready !== rng(5, 7)) begin
      $display("FAIL null_busy_ready got=%h/%h required=%h/%h",
               g_busy, g_ready, rng(0, 4), rng(5, 7));
      errors++;
    end
  endtask

  task automatic test_mid_reset;
    launch(2'b01, 2'b01, 7'd20);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL midrst_busy_before got=%b required=1", busy);
      errors++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    capture(25);
    checks++;
    if (g_p1 !== '0 || g_p2 !== '0 || g_done !== '0 || g_busy !== '0) begin
      $display("FAIL midrst_quiet got=%h/%h/%h/%h required=0",
               g_p1, g_p2, g_done, g_busy);
      errors++;
    end
    checks++;
    if (g_ready !== rng(0, 24)) begin
      $display("FAIL midrst_ready got=%h required=%h", g_ready, rng(0, 24));
      errors++;
    end
    launch(2'b01, 2'b00, 7'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pulse1 !== 1'b1) begin
      $display("FAIL midrst_p1_t0 got=%b required=1", pulse1);
      errors++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pulse1 !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL midrst_drop got p1=%b done=%b ready=%b required 0/0/1",
               pulse1, done, cmd_ready);
      errors++;
    end
    launch(2'b01, 2'b01, 7'd5);
    capture(14);
    checks++;
    if (g_p1 !== (rng(0, 1) | rng(5, 6)) || g_done !== rng(7, 7)) begin
      $display("FAIL midrst_restart got=%h/%h required=%h/%h",
               g_p1, g_done, rng(0, 1) | rng(5, 6), rng(7, 7));
      errors++;
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    cmd_start    = 2'b01;
    cmd_end      = 2'b00;
    cmd_interval = 7'd9;
    cmd_valid    = 1'b1;
    @(posedge clk);
    #1;
    cmd_start    = 2'b10;
    cmd_end      = 2'b10;
    cmd_interval = 7'd3;
    capture(14);
    cmd_valid = 1'b0;
    checks++;
    if (g_p1 !== rng(0, 1) || g_p2 !== (rng(7, 8) | rng(10, 11))) begin
      $display("FAIL b2b_pulses got=%h/%h required=%h/%h",
               g_p1, g_p2, rng(0, 1), rng(7, 8) | rng(10, 11));
      errors++;
    end
    checks++;
    if (g_done !== (rng(2, 2) | rng(12, 12))) begin
      $display("FAIL b2b_done got=%h required=%h",
               g_done, rng(2, 2) | rng(12, 12));
      errors++;
    end
    checks++;
    if (g_ready !== rng(6, 6) || g_busy !== (rng(0, 5) | rng(7, 13))) begin
      $display("FAIL b2b_ready_busy got=%h/%h required=%h/%h",
               g_ready, g_busy, rng(6, 6), rng(0, 5) | rng(7, 13));
      errors++;
    end
    capture(6);
  endtask

`ifdef TDC_PULSE_GEN_COUNT_EN
  task automatic test_count;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pair_count !== 16'd0) begin
      $display("FAIL count_reset got=%0d required=0", pair_count);
      errors++;
    end
    launch(2'b00, 2'b00, 7'd0);
    launch(2'b01, 2'b00, 7'd0);
    launch(2'b10, 2'b01, 7'd3);
    capture(20);
    checks++;
    if (pair_count !== 16'd3) begin
      $display("FAIL count_three got=%0d required=3", pair_count);
      errors++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_same_channel;
    test_coincidence;
    test_clamp;
    test_max_interval;
    test_null;
    test_mid_reset;
    test_back_to_back;
`ifdef TDC_PULSE_GEN_COUNT_EN
    test_count;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
